fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the MIPS datapath. Owns the program counter, drives the word address into the asynchronous-read instruction memory, and captures the returned instruction into the IF/ID pipeline register with a valid/ready handshake toward decode. Accepts branch/jump redirects and halt requests from later stages.

## Interface
- ADDR_W, 32, PC and instruction-memory address width
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 1, PC increment per fetch; memory is word-indexed, so 1 means the next instruction

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  address to instruction memory; combinational copy of the PC register
- imem_data  in  INSTR_W  instruction from memory; valid in the same cycle as imem_addr (async read)
- redirect_valid  in  1  taken branch/jump; load PC from redirect_target and flush
- redirect_target  in  ADDR_W  new PC
- halt_req  in  1  stop fetching after the current IF/ID contents drain
- id_ready  in  1  decode accepts IF/ID contents this cycle
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  INSTR_W  fetched instruction
- if_pc  out  ADDR_W  address the instruction was fetched from
- if_pc_next  out  ADDR_W  if_pc + PC_STEP, for link and branch-offset use
- halted  out  1  high while in HALT

## Operation
- States: BOOT, FETCH, HALT. Reset enters BOOT.
- BOOT: lasts exactly one cycle after rst_n deasserts; no capture; goes to FETCH (or HALT if halt_req is high, or FETCH with the redirected PC if redirect_valid is high).
- advance = (state == FETCH) and (!if_valid or id_ready).
- Priority each cycle: redirect_valid > halt_req > advance > hold.
- Redirect (any state): pc <= redirect_target; if_valid <= 0 (discard IF/ID even if id_ready); state <= FETCH; no capture this cycle.
- Halt (no redirect): state <= HALT; pc holds. The IF/ID entry stays until consumed (if_valid clears on id_ready), then if_valid stays 0. No new capture in the halt cycle.
- Advance: if_instr <= imem_data, if_pc <= pc, if_pc_next <= pc + PC_STEP, if_valid <= 1, pc <= pc + PC_STEP.
- Hold (if_valid && !id_ready in FETCH): pc and all IF/ID outputs unchanged.
- In HALT with no redirect: if_valid clears on id_ready; nothing else changes; halt_req deasserting does not resume. Only a redirect leaves HALT.
- Arithmetic: pc + PC_STEP truncated to ADDR_W; all-ones + 1 wraps to 0 with no flag.
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, if_pc_next = 0, halted = 0, state = BOOT.
- Reset mid-operation: the asynchronous reset returns everything to the reset values immediately, and any in-flight IF/ID entry is lost.

## Timing
- Fetch latency: PC presented in cycle N, so if_valid/if_instr for that PC are visible in cycle N+1.
- Throughput: one instruction per cycle while id_ready is high.
- Redirect penalty: redirect in cycle N, imem_addr = target in N+1, and the target instruction is valid in N+2, giving one bubble.
- First instruction after reset release: cycle 0 is BOOT, the cycle-1 fetch of RESET_PC produces if_valid in cycle 2.
- redirect and id_ready in the same cycle: the redirect wins, so the old entry is dropped and not reported as consumed.
- halted asserts the cycle after halt_req is accepted.

## Structure
- The shared mips_pkg holds the fetch state enum (BOOT/FETCH/HALT) and the default RESET_PC and PC_STEP constants used by fetch_unit and the top level.
- One sub-module: if_id_reg, a parameterised valid/ready pipeline register with load, hold and flush inputs, reused for later stage boundaries. fetch_unit keeps the PC, the FSM and the priority logic.

## Test plan
- Reset with RESET_PC=0x10 and memory[0x10..0x12] = A,B,C, id_ready=1: if_valid rises in cycle 2 and the bench sees (0x10,A), (0x11,B), (0x12,C) on consecutive cycles with if_pc_next = if_pc+1.
- id_ready low for 3 cycles with an entry held: if_instr, if_pc and imem_addr stay frozen, and on release there is no duplicate and no skipped instruction.
- redirect_valid with target 0x40 while id_ready=0: the held entry is dropped, if_valid=0 for one cycle, then (0x40, mem[0x40]).
- halt_req for one cycle with id_ready=0 for two cycles: the entry is held, then consumed, then if_valid stays 0 and halted=1 indefinitely. A later redirect to 0x8 resumes fetching at 0x8.
- PC at 0xFFFFFFFF: the next fetch is at 0x0, and if_pc_next reads 0x0 for the wrap instruction.
- rst_n pulsed low mid-stream with if_valid=1: all outputs go to their reset values immediately, and the fetch sequence restarts at RESET_PC per the reset timing.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: fetch FSM state encoding and
// the default reset PC and PC increment used by fetch_unit and the top level.
package mips_pkg;

  // Fetch-stage controller states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // Reset vector and per-fetch increment (memory is word-indexed).
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'h0000_0001;

endpackage : mips_pkg

// File: rtl/if_id_reg.sv
// Valid/ready pipeline register between two stages.
// Priority: flush > load > hold > drain (ready clears valid).
// The payload is opaque so the same block serves later stage boundaries.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic         flush,
  input  logic         ready,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Register the entry: flush drops it, load replaces it, ready consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset as well as valid, because its reset
      // value is visible on the stage outputs and must read as zero.
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, regardless of statement order.
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (hold) begin
      valid <= valid;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule : if_id_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the async-read instruction
// memory and captures the returned word into the IF/ID register. Handles
// redirects (branch/jump) and halt requests from later stages.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt_req,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_next,
  output logic               halted
);

  // IF/ID payload layout.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
  } if_id_t;

  localparam int PAYLOAD_W = INSTR_W + 2 * ADDR_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              advance;
  logic              do_load;
  logic              do_hold;
  if_id_t            capture;
  if_id_t            entry;
  logic [PAYLOAD_W-1:0] entry_bits;

  // Memory address is the PC register itself; increment wraps silently.
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_STEP;

  // Decide what the IF/ID register does this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    advance = 1'b0;
    do_load = 1'b0;
    do_hold = 1'b0;
    capture = '{instr: imem_data, pc: pc, pc_next: pc_inc};
    if (state == FETCH) begin
      advance = !if_valid || id_ready;
      do_hold = if_valid && !id_ready;
    end
    // Redirect and halt both outrank a capture.
    do_load = advance && !redirect_valid && !halt_req;
  end

  // PC, FSM state and halted flag; redirect > halt > advance > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      state  <= FETCH;
      pc     <= redirect_target;
      halted <= 1'b0;
    end else if (halt_req) begin
      state  <= HALT;
      halted <= 1'b1;
    end else begin
      unique case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (advance) pc <= pc_inc;
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

  if_id_reg #(
    .W (PAYLOAD_W)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (do_load),
    .hold  (do_hold),
    .flush (redirect_valid),
    .ready (id_ready),
    .d     (capture),
    .valid (if_valid),
    .q     (entry_bits)
  );

  // Unpack the registered entry onto the stage outputs.
  assign entry      = if_id_t'(entry_bits);
  assign if_instr   = entry.instr;
  assign if_pc      = entry.pc;
  assign if_pc_next = entry.pc_next;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory is modelled as
// mem[a] = a ^ 32'hA500_0000; expected words below are written out by hand.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA500_0000;

  fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h10),
    .PC_STEP  (32'h1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_next      (if_pc_next),
    .halted          (halted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic [31:0] pc_exp, input logic [31:0] instr_exp,
                             input logic [31:0] next_exp);
    check({tag, ".valid"},   64'(if_valid),   64'd1);
    check({tag, ".pc"},      64'(if_pc),      64'(pc_exp));
    check({tag, ".instr"},   64'(if_instr),   64'(instr_exp));
    check({tag, ".pc_next"}, 64'(if_pc_next), 64'(next_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"},   64'(if_valid),   64'd0);
    check({tag, ".addr"},    64'(imem_addr),  64'h10);
    check({tag, ".instr"},   64'(if_instr),   64'd0);
    check({tag, ".pc"},      64'(if_pc),      64'd0);
    check({tag, ".pc_next"}, 64'(if_pc_next), 64'd0);
    check({tag, ".halted"},  64'(halted),     64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    halt_req = 1'b0; id_ready = 1'b1;
    step(); step();
    check_reset_outputs("reset");

    // Release in cycle 0 (BOOT); first entry appears in cycle 2.
    rst_n = 1'b1;
    step();
    check("boot.valid", 64'(if_valid), 64'd0);
    check("boot.addr", 64'(imem_addr), 64'h10);
    step();
    check_entry("seq0", 32'h10, 32'hA500_0010, 32'h11);
    check("seq0.addr", 64'(imem_addr), 64'h11);
    step();
    check_entry("seq1", 32'h11, 32'hA500_0011, 32'h12);
    step();
    check_entry("seq2", 32'h12, 32'hA500_0012, 32'h13);

    // Stall three cycles: everything frozen.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_entry("stall", 32'h12, 32'hA500_0012, 32'h13);
      check("stall.addr", 64'(imem_addr), 64'h13);
    end
    id_ready = 1'b1;
    step();
    check_entry("release", 32'h13, 32'hA500_0013, 32'h14);

    // Redirect while stalled drops the held entry, one bubble.
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    check("redir.valid", 64'(if_valid), 64'd0);
    check("redir.addr", 64'(imem_addr), 64'h40);
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    check_entry("redir.tgt", 32'h40, 32'hA500_0040, 32'h41);

    // Redirect with id_ready high still discards the entry.
    redirect_valid = 1'b1; redirect_target = 32'h20;
    step();
    check("redir_rdy.valid", 64'(if_valid), 64'd0);
    redirect_valid = 1'b0;
    step();
    check_entry("redir_rdy.tgt", 32'h20, 32'hA500_0020, 32'h21);
    step();
    check_entry("pre_halt", 32'h21, 32'hA500_0021, 32'h22);

    // Halt for one cycle with decode stalled for two.
    halt_req = 1'b1; id_ready = 1'b0;
    step();
    check("halt.halted", 64'(halted), 64'd1);
    check_entry("halt.held", 32'h21, 32'hA500_0021, 32'h22);
    check("halt.addr", 64'(imem_addr), 64'h22);
    halt_req = 1'b0;
    step();
    check("halt2.valid", 64'(if_valid), 64'd1);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halted.valid", 64'(if_valid), 64'd0);
      check("halted.flag", 64'(halted), 64'd1);
      check("halted.addr", 64'(imem_addr), 64'h22);
    end

    // Only a redirect resumes.
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    check("resume.halted", 64'(halted), 64'd0);
    check("resume.addr", 64'(imem_addr), 64'h8);
    check("resume.valid", 64'(if_valid), 64'd0);
    redirect_valid = 1'b0;
    step();
    check_entry("resume.tgt", 32'h8, 32'hA500_0008, 32'h9);

    // PC wrap from all-ones to zero.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    check("wrap.addr", 64'(imem_addr), 64'hFFFF_FFFF);
    redirect_valid = 1'b0;
    step();
    check_entry("wrap.top", 32'hFFFF_FFFF, 32'h5AFF_FFFF, 32'h0);
    check("wrap.addr0", 64'(imem_addr), 64'h0);
    step();
    check_entry("wrap.zero", 32'h0, 32'hA500_0000, 32'h1);

    // Asynchronous reset mid-stream with a valid entry.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #1;
    rst_n = 1'b1;
    step();
    check("restart.valid", 64'(if_valid), 64'd0);
    check("restart.addr", 64'(imem_addr), 64'h10);
    step();
    check_entry("restart", 32'h10, 32'hA500_0010, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
